jump_seq_ctrl: RTL and testbench
================================

# jump_seq_ctrl

Central sequencer for the jump game: turns the debounced jump button into a charge/launch/flight/judge/scroll cycle, commands the jump trajectory block, requests a landing verdict, and maintains score, lives and game-over. It sits between the clock divider and VGA frame timing on one side and the jump, landing-judge and graphics blocks on the other. It is the only writer of game score and game state.

## Interface
- POWER_W, 8, width of charge power
- POWER_MAX, 255, charge saturation value
- CHARGE_STEP, 2, power added per frame while charging
- SCORE_W, 16, score width
- JUDGE_TIMEOUT, 4, frames to wait for a verdict
- SCROLL_FRAMES, 32, frames the scene scroll lasts
- LIVES_INIT, 3, lives at start; used only with lives enabled
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per VGA frame
- btn  in  1  debounced jump button level
- flight_done  in  1  pulse: trajectory has returned to platform height
- land_valid  in  1  pulse: landing verdict present
- land_ok  in  1  verdict; sampled only with land_valid
- state  out  3  current state code
- jump_start  out  1  one-cycle launch pulse
- jump_power  out  POWER_W  launch power
- charging  out  1  high in CHARGE
- judge_req  out  1  landing verdict request
- scroll_active  out  1  high in SCROLL
- score  out  SCORE_W  successful landings
- lives  out  2  remaining lives
- game_over  out  1  high in OVER

## Operation
- States: IDLE=0, CHARGE=1, FLIGHT=2, JUDGE=3, SCROLL=4, OVER=5.
- Button press = rising edge of btn, detected from a registered copy of btn.
- IDLE: press -> CHARGE, power cleared to 0. A button still held on entry does not start a charge.
- CHARGE: on frame_tick with btn high, power += CHARGE_STEP, saturating at POWER_MAX with no wrap. btn low -> FLIGHT; jump_power latched; jump_start pulses.
- Release and frame_tick in the same cycle: release wins and power is not incremented.
- FLIGHT: flight_done -> JUDGE. jump_power is held stable for the whole flight.
- JUDGE: judge_req is high.
  - land_valid with land_ok -> score += 1, saturating at all ones, -> SCROLL.
  - land_valid with !land_ok -> miss.
  - JUDGE_TIMEOUT frame_ticks with no land_valid -> miss.
  - land_valid in the same cycle as the final timeout tick: the verdict wins.
- Miss: see Configuration.
- SCROLL: scroll_active high for SCROLL_FRAMES frame_ticks, then IDLE.
- OVER: game_over high. Press -> score=0, lives=LIVES_INIT, -> IDLE.
- Inputs not expected in the current state are ignored: flight_done outside FLIGHT, land_valid outside JUDGE.

## Timing
- Every output is registered.
- Reset values:
  - state=IDLE; jump_power=0; score=0; lives=LIVES_INIT, or 1 without lives.
  - jump_start, charging, judge_req, scroll_active and game_over all 0.
  - Internal frame counter=0; btn history=0.
- Reset asserted mid-operation returns to the reset values on the next edge, regardless of state.
- Latencies from a registered input event to the response:
  - btn edge -> charging=1: 2 cycles, one for the edge register and one for the state register.
  - Release -> jump_start: 2 cycles. jump_start is exactly 1 cycle wide and coincides with state=FLIGHT.
  - flight_done -> judge_req: 1 cycle. judge_req drops in the cycle the state leaves JUDGE.
- The frame counter clears on every state entry and counts only frame_tick.

## Configuration
- GAME_CTRL_LIVES_EN defined:
  - A miss decrements lives.
  - lives reaching 0 -> OVER; otherwise -> SCROLL.
- Undefined:
  - lives is tied to 1.
  - Any miss -> OVER.
  - The lives decrement logic is absent.

## Structure
- Shared package game_pkg holds:
  - the state encoding localparams, as a typedef'd enum;
  - POWER_W and SCORE_W defaults;
  - the frame timing constants.
  - graphics and machine-level blocks import the same package.
- One sub-module, game_frame_timer: a frame_tick counter with a clear input and a terminal-count output. It is instantiated once and drives both the JUDGE timeout and the SCROLL duration.

## Test plan
- Charge and launch: press, 10 frame_ticks, release -> jump_power=20, one jump_start pulse, state=2.
- Saturation: hold for 200 frames -> jump_power=255, never wraps. Release coincident with frame_tick -> power unchanged.
- Successful landing: flight_done, then land_valid and land_ok -> score 0->1. Then 32 frames of scroll_active, then IDLE.
- Timeout miss with lives enabled: no land_valid for 4 frames -> lives 3->2, SCROLL. After 3 such misses -> game_over=1. A press in OVER -> score=0, lives=3, IDLE.
- Without GAME_CTRL_LIVES_EN: a single land_ok=0 verdict -> OVER.
- Reset asserted in FLIGHT with score=5 -> next cycle state=0, score=0, all pulse outputs 0. A button held through reset does not start a charge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the jump game: state encoding, datapath width
// defaults and frame timing constants. Imported by the sequencer, its frame
// timer and the graphics blocks.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHARGE = 3'd1,
        ST_FLIGHT = 3'd2,
        ST_JUDGE  = 3'd3,
        ST_SCROLL = 3'd4,
        ST_OVER   = 3'd5
    } game_state_t;

    // Datapath width defaults
    localparam int POWER_W_DEF       = 8;
    localparam int SCORE_W_DEF       = 16;
    localparam int POWER_MAX_DEF     = 255;
    localparam int CHARGE_STEP_DEF   = 2;
    localparam int LIVES_INIT_DEF    = 3;

    // Frame timing constants (counted in frame_tick pulses)
    localparam int JUDGE_TIMEOUT_DEF = 4;
    localparam int SCROLL_FRAMES_DEF = 32;
    localparam int FRAME_CNT_W       = 6;

endpackage

// File: rtl/game_frame_timer.sv
// Frame tick counter with synchronous clear and a terminal-count strobe.
// The strobe fires on the tick that completes i_limit ticks since the last
// clear; the owner clears it whenever it changes state.
module game_frame_timer
    import game_pkg::*;
#(
    parameter int CNT_W = FRAME_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    // Count frame ticks; clear has priority over a coincident tick
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tc = i_tick && (r_count == (i_limit - CNT_W'(1)));

endmodule

// File: rtl/jump_seq_ctrl.sv
// Jump game sequencer: charge / launch / flight / judge / scroll cycle,
// score, lives and game-over. All outputs are registered.
// Optional feature: define GAME_CTRL_LIVES_EN to enable multiple lives;
// otherwise lives reads 1 and any miss ends the game.
module jump_seq_ctrl
    import game_pkg::*;
#(
    parameter int POWER_W       = POWER_W_DEF,
    parameter int POWER_MAX     = POWER_MAX_DEF,
    parameter int CHARGE_STEP   = CHARGE_STEP_DEF,
    parameter int SCORE_W       = SCORE_W_DEF,
    parameter int JUDGE_TIMEOUT = JUDGE_TIMEOUT_DEF,
    parameter int SCROLL_FRAMES = SCROLL_FRAMES_DEF
`ifdef GAME_CTRL_LIVES_EN
    ,
    parameter int LIVES_INIT    = LIVES_INIT_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               btn,
    input  logic               flight_done,
    input  logic               land_valid,
    input  logic               land_ok,
    output logic [2:0]         state,
    output logic               jump_start,
    output logic [POWER_W-1:0] jump_power,
    output logic               charging,
    output logic               judge_req,
    output logic               scroll_active,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               game_over
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_CHARGE = ST_CHARGE;
    localparam logic [2:0] S_FLIGHT = ST_FLIGHT;
    localparam logic [2:0] S_JUDGE  = ST_JUDGE;
    localparam logic [2:0] S_SCROLL = ST_SCROLL;
    localparam logic [2:0] S_OVER   = ST_OVER;

    logic               r_btn_d;
    logic               r_armed;    // a low btn has been seen since reset
    logic               r_rise;     // registered press edge
    logic [2:0]         r_state;
    logic [POWER_W-1:0] r_power;
    logic [POWER_W-1:0] r_jump_power;
    logic               r_jump_start;
    logic               r_charging;
    logic               r_judge_req;
    logic               r_scroll;
    logic               r_game_over;
    logic [SCORE_W-1:0] r_score;

    logic [2:0]           w_state_next;
    logic [POWER_W-1:0]   w_power_next;
    logic [SCORE_W-1:0]   w_score_next;
    logic [POWER_W:0]     w_power_sum;
    logic                 w_miss;
    logic                 w_launch;
    logic                 w_tc;
    logic [FRAME_CNT_W-1:0] w_limit;

`ifdef GAME_CTRL_LIVES_EN
    logic [1:0] r_lives;
    logic [1:0] w_lives_next;
`endif

    assign w_power_sum = {1'b0, r_power} + (POWER_W+1)'(CHARGE_STEP);
    assign w_launch    = (r_state == S_CHARGE) && (w_state_next == S_FLIGHT);
    assign w_limit     = (r_state == S_JUDGE) ? FRAME_CNT_W'(JUDGE_TIMEOUT)
                                              : FRAME_CNT_W'(SCROLL_FRAMES);

    game_frame_timer #(
        .CNT_W (FRAME_CNT_W)
    ) u_frame_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_state_next != r_state),
        .i_tick  (frame_tick),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    // Next-state, charge power, score and (optionally) lives decisions
    always_comb begin
        w_state_next = r_state;
        w_power_next = r_power;
        w_score_next = r_score;
        w_miss       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rise) begin
                    w_state_next = S_CHARGE;
                    w_power_next = '0;
                end
            end
            S_CHARGE: begin
                // Raw btn gates the increment so a release coinciding with a
                // tick adds nothing; the registered copy drives the launch.
                if (!r_btn_d) begin
                    w_state_next = S_FLIGHT;
                end else if (frame_tick && btn) begin
                    if (w_power_sum > (POWER_W+1)'(POWER_MAX)) begin
                        w_power_next = POWER_W'(POWER_MAX);
                    end else begin
                        w_power_next = w_power_sum[POWER_W-1:0];
                    end
                end
            end
            S_FLIGHT: begin
                if (flight_done) begin
                    w_state_next = S_JUDGE;
                end
            end
            S_JUDGE: begin
                // A verdict outranks a timeout arriving in the same cycle
                if (land_valid) begin
                    if (land_ok) begin
                        if (r_score != '1) begin
                            w_score_next = r_score + SCORE_W'(1);
                        end
                        w_state_next = S_SCROLL;
                    end else begin
                        w_miss = 1'b1;
                    end
                end else if (w_tc) begin
                    w_miss = 1'b1;
                end
            end
            S_SCROLL: begin
                if (w_tc) begin
                    w_state_next = S_IDLE;
                end
            end
            S_OVER: begin
                if (r_rise) begin
                    w_state_next = S_IDLE;
                    w_score_next = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
`ifdef GAME_CTRL_LIVES_EN
        w_lives_next = r_lives;
        if (r_state == S_OVER && r_rise) begin
            w_lives_next = 2'(LIVES_INIT);
        end
        if (w_miss) begin
            if (r_lives <= 2'd1) begin
                w_lives_next = 2'd0;
                w_state_next = S_OVER;
            end else begin
                w_lives_next = r_lives - 2'd1;
                w_state_next = S_SCROLL;
            end
        end
`else
        if (w_miss) begin
            w_state_next = S_OVER;
        end
`endif
    end

    // Button edge pipeline, state register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_d      <= 1'b0;
            r_armed      <= 1'b0;
            r_rise       <= 1'b0;
            r_state      <= S_IDLE;
            r_power      <= '0;
            r_jump_power <= '0;
            r_jump_start <= 1'b0;
            r_charging   <= 1'b0;
            r_judge_req  <= 1'b0;
            r_scroll     <= 1'b0;
            r_game_over  <= 1'b0;
            r_score      <= '0;
        end else begin
            r_btn_d      <= btn;
            r_armed      <= r_armed | ~btn;
            r_rise       <= btn & ~r_btn_d & r_armed;
            r_state      <= w_state_next;
            r_power      <= w_power_next;
            r_score      <= w_score_next;
            r_jump_start <= w_launch;
            if (w_launch) begin
                r_jump_power <= r_power;
            end
            r_charging   <= (w_state_next == S_CHARGE);
            r_judge_req  <= (w_state_next == S_JUDGE);
            r_scroll     <= (w_state_next == S_SCROLL);
            r_game_over  <= (w_state_next == S_OVER);
        end
    end

`ifdef GAME_CTRL_LIVES_EN
    // Remaining lives, restored on reset and on restart from game over
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lives <= 2'(LIVES_INIT);
        end else begin
            r_lives <= w_lives_next;
        end
    end
    assign lives = r_lives;
`else
    assign lives = 2'd1;
`endif

    assign state         = r_state;
    assign jump_start    = r_jump_start;
    assign jump_power    = r_jump_power;
    assign charging      = r_charging;
    assign judge_req     = r_judge_req;
    assign scroll_active = r_scroll;
    assign score         = r_score;
    assign game_over     = r_game_over;

endmodule

// File: tb/tb_jump_seq_ctrl.sv
// Directed scoreboard bench for jump_seq_ctrl. Expected values are queued
// when stimulus is applied and compared when the DUT output is sampled.
// Works with or without GAME_CTRL_LIVES_EN.
module tb_jump_seq_ctrl;

`ifdef GAME_CTRL_LIVES_EN
    localparam int LIVES0 = 3;
`else
    localparam int LIVES0 = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, frame_tick, btn, flight_done, land_valid, land_ok;
    logic [2:0]  state;
    logic        jump_start, charging, judge_req, scroll_active, game_over;
    logic [7:0]  jump_power;
    logic [15:0] score;
    logic [1:0]  lives;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    jump_seq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .btn           (btn),
        .flight_done   (flight_done),
        .land_valid    (land_valid),
        .land_ok       (land_ok),
        .state         (state),
        .jump_start    (jump_start),
        .jump_power    (jump_power),
        .charging      (charging),
        .judge_req     (judge_req),
        .scroll_active (scroll_active),
        .score         (score),
        .lives         (lives),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic ob(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
            $display("chk %-14s observed=%0d expected=%0d", e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press();
        btn = 1'b1;
        step();
        step();
    endtask

    task automatic release_btn();
        btn = 1'b0;
        step();
        step();
    endtask

    task automatic to_judge();
        flight_done = 1'b1;
        step();
        flight_done = 1'b0;
    endtask

    task automatic verdict(input logic ok);
        land_valid = 1'b1;
        land_ok    = ok;
        step();
        land_valid = 1'b0;
        land_ok    = 1'b0;
    endtask

    task automatic good_round();
        press();
        ticks(1);
        release_btn();
        to_judge();
        verdict(1'b1);
        ticks(32);
    endtask

    task automatic launch_one();
        press();
        ticks(1);
        release_btn();
        to_judge();
    endtask

    initial begin
        rst = 1'b1; btn = 1'b0; frame_tick = 1'b0;
        flight_done = 1'b0; land_valid = 1'b0; land_ok = 1'b0;
        step();
        step();
        // reset values
        ex("rst_state", 0); ex("rst_jpower", 0); ex("rst_score", 0);
        ex("rst_lives", LIVES0); ex("rst_jstart", 0); ex("rst_charging", 0);
        ex("rst_jreq", 0); ex("rst_scroll", 0); ex("rst_over", 0);
        ob(state); ob(jump_power); ob(score); ob(lives); ob(jump_start);
        ob(charging); ob(judge_req); ob(scroll_active); ob(game_over);
        rst = 1'b0;
        step();

        // flight_done / land_valid ignored in IDLE
        ex("idle_ign_st", 0); ex("idle_ign_sc", 0);
        flight_done = 1'b1; land_valid = 1'b1; land_ok = 1'b1;
        step();
        flight_done = 1'b0; land_valid = 1'b0; land_ok = 1'b0;
        ob(state); ob(score);

        // press -> charging after two edges
        ex("chg_lat1", 0);
        btn = 1'b1;
        step();
        ob(charging);
        ex("chg_lat2", 1); ex("st_charge", 1);
        step();
        ob(charging); ob(state);

        // 10 ticks, release coincident with an 11th tick (must not count)
        ticks(10);
        ex("js_lat1", 0);
        btn = 1'b0; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        ob(jump_start);
        ex("jstart", 1); ex("st_flight", 2); ex("jpower20", 20);
        step();
        ob(jump_start); ob(state); ob(jump_power);
        ex("js_width", 0); ex("chg_off", 0);
        step();
        ob(jump_start); ob(charging);

        // land_valid ignored during FLIGHT
        ex("flt_ign_st", 2); ex("jp_hold", 20);
        land_valid = 1'b1; land_ok = 1'b1;
        step();
        land_valid = 1'b0; land_ok = 1'b0;
        ob(state); ob(jump_power);

        // flight_done -> JUDGE, then good verdict
        ex("jreq_on", 1); ex("st_judge", 3);
        to_judge();
        ob(judge_req); ob(state);
        ex("st_scroll", 4); ex("score1", 1); ex("jreq_drop", 0); ex("scroll_on", 1);
        verdict(1'b1);
        ob(state); ob(score); ob(judge_req); ob(scroll_active);
        ticks(31);
        ex("scroll_31", 1);
        ob(scroll_active);
        ex("scroll_end", 0); ex("st_idle", 0);
        tick();
        ob(scroll_active); ob(state);

        // saturation
        press();
        ticks(200);
        ex("jp_sat", 255);
        release_btn();
        ob(jump_power);

        // verdict coinciding with the final timeout tick wins
        to_judge();
        ticks(3);
        ex("st_judge3", 3);
        ob(state);
        ex("verd_win_st", 4); ex("score2", 2);
        land_valid = 1'b1; land_ok = 1'b1; frame_tick = 1'b1;
        step();
        land_valid = 1'b0; land_ok = 1'b0; frame_tick = 1'b0;
        ob(state); ob(score);
        ticks(32);
        repeat (3) good_round();
        ex("score5", 5);
        ob(score);

        // reset during FLIGHT with the button held
        press();
        ticks(3);
        release_btn();
        ex("st_flight2", 2);
        ob(state);
        btn = 1'b1; rst = 1'b1;
        step();
        ex("mid_rst_st", 0); ex("mid_rst_sc", 0); ex("mid_rst_jp", 0);
        ex("mid_rst_js", 0); ex("mid_rst_chg", 0); ex("mid_rst_jrq", 0);
        ex("mid_rst_scr", 0); ex("mid_rst_ovr", 0);
        ob(state); ob(score); ob(jump_power); ob(jump_start);
        ob(charging); ob(judge_req); ob(scroll_active); ob(game_over);
        rst = 1'b0;
        step(); step(); step();
        ex("held_no_chg", 0); ex("held_st", 0);
        ob(charging); ob(state);
        btn = 1'b0;
        step();
        good_round();
        ex("score_after", 1);
        ob(score);

        // misses
`ifdef GAME_CTRL_LIVES_EN
        launch_one();
        ticks(4);
        ex("miss1_lives", 2); ex("miss1_st", 4);
        ob(lives); ob(state);
        ticks(32);
        launch_one();
        verdict(1'b0);
        ex("miss2_lives", 1); ex("miss2_st", 4);
        ob(lives); ob(state);
        ticks(32);
        launch_one();
        ticks(4);
        ex("miss3_lives", 0); ex("miss3_st", 5); ex("over_flag", 1);
        ob(lives); ob(state); ob(game_over);
`else
        launch_one();
        verdict(1'b0);
        ex("bad_verd_st", 5); ex("over_flag", 1); ex("lives_tied", 1);
        ob(state); ob(game_over); ob(lives);
`endif

        // restart from OVER
        ex("restart_st", 0); ex("restart_sc", 0); ex("restart_lv", LIVES0);
        ex("restart_ovr", 0);
        press();
        ob(state); ob(score); ob(lives); ob(game_over);
        step(); step();
        ex("restart_hold", 0);
        ob(state);
        btn = 1'b0;
        step();

`ifndef GAME_CTRL_LIVES_EN
        // timeout miss also ends the game
        launch_one();
        ticks(3);
        ex("to3_st", 3);
        ob(state);
        tick();
        ex("timeout_st", 5);
        ob(state);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
